// File: rtl/mul_share_pkg.sv
// Shared types and flag helper for the shared multiplier controller.
// The controller's MUL_SHARE_STAGE2_EN option adds an operand register stage (state MUL).
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } mul_share_state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } mul_flags_t;

  // v is set when the operand sign bits agree but the truncated result looks negative.
  function automatic mul_flags_t make_flags(input logic msb_a, input logic msb_b,
                                            input logic res_zero, input logic res_msb,
                                            input logic hi_nonzero);
    mul_flags_t f;
    f.z = res_zero;
    f.n = res_msb;
    f.c = hi_nonzero;
    f.v = (msb_a ~^ msb_b) & res_msb;
    return f;
  endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
// The pointer register lives in the parent.
module mul_rr_arbiter
  import mul_share_pkg::*;
#(
  parameter  int R    = 4,
  localparam int ID_W = $clog2(R)
) (
  input  logic [R-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [R-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] idx_s;
  logic            found_s;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 1; k <= R; k++) begin
      idx_s = ID_W'((int'(ptr) + k) % R);
      if (en && !found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_id     = idx_s;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// One N-bit multiplier shared by R requesters with round-robin grant and a held, tagged result.
// Define MUL_SHARE_STAGE2_EN to insert an operand register stage (latency 2, no back-to-back).
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int R    = 4,
  localparam int ID_W = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    req_valid,
  input  logic [R*N-1:0]  req_a,
  input  logic [R*N-1:0]  req_b,
  output logic [R-1:0]    req_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [ID_W-1:0] resp_id,
  output logic [N-1:0]    resp_result,
  output logic            resp_z,
  output logic            resp_n,
  output logic            resp_c,
  output logic            resp_v
);

  mul_share_state_t state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [N-1:0]     resp_result_q, resp_result_d;
  mul_flags_t       resp_flags_q, resp_flags_d;

  logic             arb_en_s;
  logic [R-1:0]     gnt_s;
  logic [ID_W-1:0]  gnt_id_s;
  logic             accept_s;
  logic [N-1:0]     sel_a_s, sel_b_s, mul_a_s, mul_b_s, prod_lo_s;
  logic [ID_W-1:0]  mul_id_s;
  logic [2*N-1:0]   prod_s;
  mul_flags_t       prod_flags_s;

`ifdef MUL_SHARE_STAGE2_EN
  logic [N-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ID_W-1:0]  op_id_q, op_id_d;
  assign arb_en_s = (state_q == IDLE);
  assign mul_a_s  = op_a_q;
  assign mul_b_s  = op_b_q;
  assign mul_id_s = op_id_q;
`else
  // Grants may overlap the consume cycle so a held result never costs a bubble.
  assign arb_en_s = (state_q == IDLE) || ((state_q == HOLD) && resp_ready);
  assign mul_a_s  = sel_a_s;
  assign mul_b_s  = sel_b_s;
  assign mul_id_s = gnt_id_s;
`endif

  mul_rr_arbiter #(.R(R)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (arb_en_s),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

  assign accept_s  = |gnt_s;
  assign req_ready = gnt_s;

  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < R; i++) begin
      if (gnt_s[i]) begin
        sel_a_s = req_a[i*N +: N];
        sel_b_s = req_b[i*N +: N];
      end else begin
        sel_a_s = sel_a_s;
      end
    end
  end

  assign prod_s       = {{N{1'b0}}, mul_a_s} * {{N{1'b0}}, mul_b_s};
  assign prod_lo_s    = prod_s[N-1:0];
  assign prod_flags_s = make_flags(mul_a_s[N-1], mul_b_s[N-1], prod_lo_s == '0,
                                   prod_lo_s[N-1], |prod_s[2*N-1:N]);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
`ifdef MUL_SHARE_STAGE2_EN
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_id_d       = op_id_q;
`endif
    if (accept_s) begin
      rr_ptr_d = gnt_id_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    case (state_q)
      IDLE: begin
        if (accept_s) begin
`ifdef MUL_SHARE_STAGE2_EN
          state_d = MUL;
          op_a_d  = sel_a_s;
          op_b_d  = sel_b_s;
          op_id_d = gnt_id_s;
`else
          state_d       = HOLD;
          resp_valid_d  = 1'b1;
          resp_id_d     = mul_id_s;
          resp_result_d = prod_lo_s;
          resp_flags_d  = prod_flags_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
`ifdef MUL_SHARE_STAGE2_EN
        state_d       = HOLD;
        resp_valid_d  = 1'b1;
        resp_id_d     = mul_id_s;
        resp_result_d = prod_lo_s;
        resp_flags_d  = prod_flags_s;
`else
        state_d = IDLE;
`endif
      end
      HOLD: begin
        if (resp_ready) begin
`ifdef MUL_SHARE_STAGE2_EN
          state_d      = IDLE;
          resp_valid_d = 1'b0;
`else
          if (accept_s) begin
            state_d       = HOLD;
            resp_valid_d  = 1'b1;
            resp_id_d     = mul_id_s;
            resp_result_d = prod_lo_s;
            resp_flags_d  = prod_flags_s;
          end else begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
          end
`endif
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // rr_ptr resets to R-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= ID_W'(R - 1);
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
`ifdef MUL_SHARE_STAGE2_EN
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_id_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
`ifdef MUL_SHARE_STAGE2_EN
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_id_q       <= op_id_d;
`endif
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_z      = resp_flags_q.z;
  assign resp_n      = resp_flags_q.n;
  assign resp_c      = resp_flags_q.c;
  assign resp_v      = resp_flags_q.v;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl (default build): directed cases plus randomized traffic
// compared every cycle against a transaction-level model of grant order and held result.
module tb_mul_share_ctrl;

  localparam int N    = 32;
  localparam int R    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [R-1:0]    req_valid;
  logic [R*N-1:0]  req_a, req_b;
  logic [R-1:0]    req_ready;
  logic            resp_valid, resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [N-1:0]    resp_result;
  logic            resp_z, resp_n, resp_c, resp_v;

  int checks   = 0;
  int failures = 0;

  // Model: the held response (if any) and the last requester served.
  bit              m_valid;
  logic [ID_W-1:0] m_id;
  logic [N-1:0]    m_result;
  logic [3:0]      m_flags;
  int              m_last;

  mul_share_ctrl #(.N(N), .R(R)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_z(resp_z), .resp_n(resp_n), .resp_c(resp_c), .resp_v(resp_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_id     = '0;
    m_result = '0;
    m_flags  = '0;
    m_last   = R - 1;
  endtask

  function automatic int pick_winner();
    for (int k = 1; k <= R; k++) begin
      int idx;
      idx = (m_last + k) % R;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'h4000_0000;
      4: return 32'hFFFF_FFFF;
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic check_resp();
    check("resp_valid", 64'(resp_valid), 64'(m_valid));
    if (m_valid) begin
      check("resp_id", 64'(resp_id), 64'(m_id));
      check("resp_result", 64'(resp_result), 64'(m_result));
      check("resp_flags", 64'({resp_z, resp_n, resp_c, resp_v}), 64'(m_flags));
    end
  endtask

  // One clock: inputs already driven (after a negedge); check grant, advance model, check response.
  task automatic step();
    int         w;
    bit         open;
    logic [R-1:0] exp_rdy;
    logic [N-1:0] a, b;
    logic [2*N-1:0] p;
    #1;
    w       = pick_winner();
    open    = !m_valid || resp_ready;
    exp_rdy = '0;
    if (open && w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (m_valid && resp_ready) m_valid = 1'b0;
    if (open && w >= 0) begin
      a        = req_a[w*N +: N];
      b        = req_b[w*N +: N];
      p        = {32'd0, a} * {32'd0, b};
      m_result = p[N-1:0];
      m_flags  = {m_result == 32'd0, m_result[N-1], p[2*N-1:N] != 32'd0,
                  (a[N-1] == b[N-1]) && m_result[N-1]};
      m_id     = ID_W'(w);
      m_valid  = 1'b1;
      m_last   = w;
    end
    @(negedge clk);
    check_resp();
  endtask

  task automatic check_lit(input string name, input logic [N-1:0] res, input logic [ID_W-1:0] id,
                           input logic [3:0] zncv);
    check({name, "_valid"}, 64'(resp_valid), 64'd1);
    check({name, "_result"}, 64'(resp_result), 64'(res));
    check({name, "_id"}, 64'(resp_id), 64'(id));
    check({name, "_zncv"}, 64'({resp_z, resp_n, resp_c, resp_v}), 64'(zncv));
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_id", 64'(resp_id), 64'd0);
    check("rst_result", 64'(resp_result), 64'd0);
    check("rst_flags", 64'({resp_z, resp_n, resp_c, resp_v}), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    // 3*5 from requester 0
    req_valid = 4'b0001; req_a[0*N +: N] = 32'd3; req_b[0*N +: N] = 32'd5; resp_ready = 1'b1;
    step();
    check_lit("t1", 32'd15, 2'd0, 4'b0000);

    // requester 2: product exactly 2^32
    req_valid = 4'b0100; req_a[2*N +: N] = 32'h8000_0000; req_b[2*N +: N] = 32'd2;
    step();
    check_lit("t2", 32'h0000_0000, 2'd2, 4'b1010);

    // requester 3: positive operands, negative-looking result
    req_valid = 4'b1000; req_a[3*N +: N] = 32'h4000_0000; req_b[3*N +: N] = 32'd2;
    step();
    check_lit("t3", 32'h8000_0000, 2'd3, 4'b0101);

    // all requesters pending: strict rotation 0,1,2,3,0
    req_valid = 4'b1111;
    for (int i = 0; i < R; i++) begin
      req_a[i*N +: N] = rand_operand();
      req_b[i*N +: N] = rand_operand();
    end
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_rr_id", 64'(resp_id), 64'(i % R));
    end

    // back-pressure: result held, no grants, then req 1 taken on the consume cycle
    req_valid = 4'b0010; resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_ready_held", 64'(req_ready), 64'd0);
      check("t5_id_held", 64'(resp_id), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("t5_ready_release", 64'(req_ready), 64'b0010);
    step();
    check("t5_id_next", 64'(resp_id), 64'd1);

    // async reset while a result is held
    resp_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(resp_valid), 64'd0);
    check("t6_rst_id", 64'(resp_id), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req_valid = 4'b1110; resp_ready = 1'b1;
    step();
    check("t6_first_id", 64'(resp_id), 64'd1);
    check("t6_first_valid", 64'(resp_valid), 64'd1);

    // randomized traffic, including requesters withdrawing before service
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < R; i++) begin
        req_a[i*N +: N] = rand_operand();
        req_b[i*N +: N] = rand_operand();
      end
      resp_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
